// File: rtl/sample_iterator_pkg.sv
// Shared raster definitions: iterator state, MSAA one-hot codes, step-shift map.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sample_iterator_pkg;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_TEST = 1'b1
    } state_t;

    // One-hot multisample rates as presented by the bbox stage
    localparam logic [3:0] SS_1X  = 4'b1000;
    localparam logic [3:0] SS_4X  = 4'b0100;
    localparam logic [3:0] SS_16X = 4'b0010;
    localparam logic [3:0] SS_64X = 4'b0001;

    // Right-shift applied to one pixel (1<<RADIX) to get the sample pitch.
    // Illegal (non one-hot) codes fall back to 1x so the walk still terminates.
    function automatic logic [1:0] step_shift(input logic [3:0] ss);
        logic [1:0] k;
        case (ss)
            SS_1X:   k = 2'd0;
            SS_4X:   k = 2'd1;
            SS_16X:  k = 2'd2;
            SS_64X:  k = 2'd3;
            default: k = 2'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/dff.sv
// Generic enabled register with synchronous active-high clear.
// Latency: 1 cycle from d to q when en is high.
// Backpressure: none; holds q while en is low.
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d on enable, clear on reset
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/sample_step_dec.sv
// Decodes the one-hot MSAA rate into the fixed-point sample pitch.
// Latency: combinational; the caller registers the result at triangle accept.
// Backpressure: none.
module sample_step_dec
    import sample_iterator_pkg::*;
#(
    parameter int P_SIGFIG = SIGFIG,
    parameter int P_RADIX  = RADIX
) (
    input  logic [3:0]          i_sub_sample,
    output logic [P_SIGFIG-1:0] o_step
);

    localparam logic [P_SIGFIG-1:0] ONE_PIXEL = P_SIGFIG'(1) << P_RADIX;

    logic [1:0] w_shift;

    // Pitch = one pixel divided by 1/2/4/8 for 1x/4x/16x/64x
    always_comb begin
        w_shift = step_shift(i_sub_sample);
        o_step  = ONE_PIXEL >> w_shift;
    end

endmodule

// File: rtl/sample_iterator.sv
// Walks every grid sample of a triangle's bounding box in raster order, one per cycle.
// Latency: first sample valid the cycle after accept; W*H consecutive valid cycles per box.
// Backpressure: halt_RnnnnL low while busy; SAMPLE_ITER_OVERLAP_EN also opens halt on the last sample.
module sample_iterator
    import sample_iterator_pkg::*;
#(
    parameter int P_SIGFIG = SIGFIG,
    parameter int P_RADIX  = RADIX,
    parameter int P_VERTS  = VERTS,
    parameter int P_AXIS   = AXIS,
    parameter int P_COLORS = COLORS
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic signed [P_VERTS-1:0][P_AXIS-1:0][P_SIGFIG-1:0] tri_R13S,
    input  logic        [P_COLORS-1:0][P_SIGFIG-1:0]        color_R13U,
    input  logic signed [1:0][1:0][P_SIGFIG-1:0]            box_R13S,
    input  logic                                            validTri_R13H,
    input  logic        [3:0]                               subSample_RnnnnU,
    output logic                                            halt_RnnnnL,
    output logic signed [P_VERTS-1:0][P_AXIS-1:0][P_SIGFIG-1:0] tri_R14S,
    output logic        [P_COLORS-1:0][P_SIGFIG-1:0]        color_R14U,
    output logic signed [1:0][P_SIGFIG-1:0]                 sample_R14S,
    output logic                                            validSamp_R14H
);

    localparam int TRI_W   = P_VERTS * P_AXIS * P_SIGFIG;
    localparam int COLOR_W = P_COLORS * P_SIGFIG;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [P_SIGFIG-1:0] r_x, r_y;
    logic signed [P_SIGFIG-1:0] r_ll_x, r_ur_x, r_ur_y;
    logic        [P_SIGFIG-1:0] r_step;
    logic        [P_SIGFIG-1:0] w_step;
    logic                       w_last;
    logic                       w_accept;
    logic        [TRI_W-1:0]    w_tri_q;
    logic        [COLOR_W-1:0]  w_color_q;

    // Last sample of the box: the current position has reached upper-right
    assign w_last = (r_state == ST_TEST) && (r_x == r_ur_x) && (r_y == r_ur_y);

    // A new triangle is taken when idle, or on the final sample if overlap is built in
`ifdef SAMPLE_ITER_OVERLAP_EN
    assign w_accept = validTri_R13H && ((r_state == ST_WAIT) || w_last);
`else
    assign w_accept = validTri_R13H && (r_state == ST_WAIT);
`endif

    sample_step_dec #(
        .P_SIGFIG (P_SIGFIG),
        .P_RADIX  (P_RADIX)
    ) u_step_dec (
        .i_sub_sample (subSample_RnnnnU),
        .o_step       (w_step)
    );

    // Triangle and colour are held for every sample of the triangle
    dff #(.W(TRI_W)) u_tri_reg (
        .clk (clk),
        .rst (rst),
        .en  (w_accept),
        .d   (tri_R13S),
        .q   (w_tri_q)
    );

    dff #(.W(COLOR_W)) u_color_reg (
        .clk (clk),
        .rst (rst),
        .en  (w_accept),
        .d   (color_R13U),
        .q   (w_color_q)
    );

    assign tri_R14S   = w_tri_q;
    assign color_R14U = w_color_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_WAIT;
        else     r_state <= w_state_nxt;
    end

    // Next-state: leave WAIT on accept, leave TEST after the last sample unless re-accepting
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT: if (w_accept) w_state_nxt = ST_TEST;
            ST_TEST: if (w_last)   w_state_nxt = w_accept ? ST_TEST : ST_WAIT;
            default:               w_state_nxt = ST_WAIT;
        endcase
    end

    // Outputs decoded from state (and the registered last-sample condition)
    always_comb begin
        halt_RnnnnL    = 1'b1;
        validSamp_R14H = 1'b0;
        if (r_state == ST_TEST) begin
            validSamp_R14H = 1'b1;
`ifdef SAMPLE_ITER_OVERLAP_EN
            halt_RnnnnL    = w_last;
`else
            halt_RnnnnL    = 1'b0;
`endif
        end
    end

    // Iteration registers: load lower-left on accept, then step x, wrapping to the next row at ur_x
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_ll_x <= '0;
            r_ur_x <= '0;
            r_ur_y <= '0;
            r_step <= '0;
        end else if (w_accept) begin
            r_x    <= box_R13S[0][0];
            r_y    <= box_R13S[0][1];
            r_ll_x <= box_R13S[0][0];
            r_ur_x <= box_R13S[1][0];
            r_ur_y <= box_R13S[1][1];
            r_step <= w_step;
        end else if ((r_state == ST_TEST) && !w_last) begin
            if (r_x != r_ur_x) begin
                r_x <= r_x + $signed(r_step);
            end else begin
                r_x <= r_ll_x;
                r_y <= r_y + $signed(r_step);
            end
        end
    end

    assign sample_R14S[0] = r_x;
    assign sample_R14S[1] = r_y;

endmodule

// File: tb/tb_sample_iterator.sv
// Directed bench for sample_iterator: reset, 1x/4x/64x walks, ignored re-request, back-to-back.
// Latency: checks first sample one cycle after the accept edge.
// Backpressure: expected halt/valid patterns follow SAMPLE_ITER_OVERLAP_EN when defined.
module tb_sample_iterator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                                rst;
    logic signed [2:0][2:0][23:0]        tri_R13S;
    logic        [2:0][23:0]             color_R13U;
    logic signed [1:0][1:0][23:0]        box_R13S;
    logic                                validTri_R13H;
    logic        [3:0]                   subSample_RnnnnU;
    logic                                halt_RnnnnL;
    logic signed [2:0][2:0][23:0]        tri_R14S;
    logic        [2:0][23:0]             color_R14U;
    logic signed [1:0][23:0]             sample_R14S;
    logic                                validSamp_R14H;

    int checks = 0;
    int errors = 0;

    sample_iterator dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_R13S),
        .color_R13U       (color_R13U),
        .box_R13S         (box_R13S),
        .validTri_R13H    (validTri_R13H),
        .subSample_RnnnnU (subSample_RnnnnU),
        .halt_RnnnnL      (halt_RnnnnL),
        .tri_R14S         (tri_R14S),
        .color_R14U       (color_R14U),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H)
    );

    // Advance one clock and settle past the edge before observing
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a triangle with a seed-derived vertex/colour pattern and raise validTri
    task automatic load(input int seed, input int llx, input int lly,
                        input int urx, input int ury, input logic [3:0] ss);
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                tri_R13S[v][a] = 24'(seed * 100 + v * 3 + a);
        for (int c = 0; c < 3; c++)
            color_R13U[c] = 24'(seed * 1000 + c);
        box_R13S[0][0]   = 24'(llx);
        box_R13S[0][1]   = 24'(lly);
        box_R13S[1][0]   = 24'(urx);
        box_R13S[1][1]   = 24'(ury);
        subSample_RnnnnU = ss;
        validTri_R13H    = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        validTri_R13H = 1'b0;
        tri_R13S = '0;
        color_R13U = '0;
        box_R13S = '0;
        subSample_RnnnnU = 4'b1000;
        tick();
        tick();
        checks++;
        if (validSamp_R14H !== 1'b0 || halt_RnnnnL !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctl got valid=%b halt=%b want valid=0 halt=1", validSamp_R14H, halt_RnnnnL);
        end
        checks++;
        if (sample_R14S !== '0 || tri_R14S !== '0 || color_R14U !== '0) begin
            errors++;
            $display("FAIL reset_data got sample=%h tri=%h color=%h want all zero", sample_R14S, tri_R14S, color_R14U);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_1x();
        int ex[2] = '{1024, 2048};
        logic exp_halt;
        load(1, 1024, 2048, 2048, 2048, 4'b1000);
        tick();
        validTri_R13H = 1'b0;
        for (int i = 0; i < 2; i++) begin
`ifdef SAMPLE_ITER_OVERLAP_EN
            exp_halt = (i == 1);
`else
            exp_halt = 1'b0;
`endif
            checks++;
            if (validSamp_R14H !== 1'b1 || halt_RnnnnL !== exp_halt ||
                sample_R14S[0] !== 24'(ex[i]) || sample_R14S[1] !== 24'd2048) begin
                errors++;
                $display("FAIL 1x_samp%0d got v=%b halt=%b (%0d,%0d) want v=1 halt=%b (%0d,2048)",
                         i, validSamp_R14H, halt_RnnnnL, sample_R14S[0], sample_R14S[1], exp_halt, ex[i]);
            end
            tick();
        end
        checks++;
        if (validSamp_R14H !== 1'b0 || halt_RnnnnL !== 1'b1) begin
            errors++;
            $display("FAIL 1x_done got valid=%b halt=%b want valid=0 halt=1", validSamp_R14H, halt_RnnnnL);
        end
        tick();
    endtask

    task automatic test_4x();
        int ex[4] = '{0, 512, 0, 512};
        int ey[4] = '{0, 0, 512, 512};
        int bad;
        load(2, 0, 0, 512, 512, 4'b0100);
        tick();
        validTri_R13H = 1'b0;
        // Scramble the inputs: latched outputs must not follow them
        tri_R13S = '1;
        color_R13U = '1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (validSamp_R14H !== 1'b1 || sample_R14S[0] !== 24'(ex[i]) || sample_R14S[1] !== 24'(ey[i])) begin
                errors++;
                $display("FAIL 4x_samp%0d got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                         i, validSamp_R14H, sample_R14S[0], sample_R14S[1], ex[i], ey[i]);
            end
            bad = 0;
            for (int v = 0; v < 3; v++)
                for (int a = 0; a < 3; a++)
                    if (tri_R14S[v][a] !== 24'(200 + v * 3 + a)) bad++;
            for (int c = 0; c < 3; c++)
                if (color_R14U[c] !== 24'(2000 + c)) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL 4x_hold%0d got %0d tri/colour fields wrong want 0", i, bad);
            end
            tick();
        end
        checks++;
        if (validSamp_R14H !== 1'b0) begin
            errors++;
            $display("FAIL 4x_done got valid=%b want 0", validSamp_R14H);
        end
        tick();
    endtask

    task automatic test_degenerate();
        load(3, 3072, 1024, 3072, 1024, 4'b0001);
        tick();
        validTri_R13H = 1'b0;
        checks++;
        if (validSamp_R14H !== 1'b1 || sample_R14S[0] !== 24'd3072 || sample_R14S[1] !== 24'd1024 ||
            tri_R14S[0][0] !== 24'd300) begin
            errors++;
            $display("FAIL degen_samp got v=%b (%0d,%0d) tri00=%0d want v=1 (3072,1024) tri00=300",
                     validSamp_R14H, sample_R14S[0], sample_R14S[1], tri_R14S[0][0]);
        end
        tick();
        checks++;
        if (validSamp_R14H !== 1'b0 || halt_RnnnnL !== 1'b1) begin
            errors++;
            $display("FAIL degen_done got valid=%b halt=%b want valid=0 halt=1", validSamp_R14H, halt_RnnnnL);
        end
        tick();
    endtask

    task automatic test_ignore();
        int ex[4] = '{0, 512, 0, 512};
        int ey[4] = '{0, 0, 512, 512};
        load(4, 0, 0, 512, 512, 4'b0100);
        tick();
        validTri_R13H = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (validSamp_R14H !== 1'b1 || sample_R14S[0] !== 24'(ex[i]) || sample_R14S[1] !== 24'(ey[i]) ||
                tri_R14S[2][2] !== 24'd408 || color_R14U[1] !== 24'd4001) begin
                errors++;
                $display("FAIL ignore_samp%0d got v=%b (%0d,%0d) tri22=%0d col1=%0d want v=1 (%0d,%0d) tri22=408 col1=4001",
                         i, validSamp_R14H, sample_R14S[0], sample_R14S[1], tri_R14S[2][2], color_R14U[1], ex[i], ey[i]);
            end
            // One-cycle request for a different triangle while busy
            if (i == 0) load(5, 1024, 1024, 2048, 2048, 4'b1000);
            tick();
            validTri_R13H = 1'b0;
        end
        checks++;
        if (validSamp_R14H !== 1'b0) begin
            errors++;
            $display("FAIL ignore_done got valid=%b want 0", validSamp_R14H);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        load(6, 0, 0, 0, 0, 4'b1000);
        tick();
        load(7, 1024, 1024, 1024, 1024, 4'b1000);
        checks++;
        if (validSamp_R14H !== 1'b1 || sample_R14S[0] !== 24'd0 || sample_R14S[1] !== 24'd0 ||
            tri_R14S[0][0] !== 24'd600) begin
            errors++;
            $display("FAIL b2b_first got v=%b (%0d,%0d) tri00=%0d want v=1 (0,0) tri00=600",
                     validSamp_R14H, sample_R14S[0], sample_R14S[1], tri_R14S[0][0]);
        end
        tick();
`ifndef SAMPLE_ITER_OVERLAP_EN
        checks++;
        if (validSamp_R14H !== 1'b0) begin
            errors++;
            $display("FAIL b2b_bubble got valid=%b want 0", validSamp_R14H);
        end
        tick();
`endif
        validTri_R13H = 1'b0;
        checks++;
        if (validSamp_R14H !== 1'b1 || sample_R14S[0] !== 24'd1024 || sample_R14S[1] !== 24'd1024 ||
            tri_R14S[0][0] !== 24'd700) begin
            errors++;
            $display("FAIL b2b_second got v=%b (%0d,%0d) tri00=%0d want v=1 (1024,1024) tri00=700",
                     validSamp_R14H, sample_R14S[0], sample_R14S[1], tri_R14S[0][0]);
        end
        tick();
        checks++;
        if (validSamp_R14H !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done got valid=%b want 0", validSamp_R14H);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int late;
        load(8, 0, 0, 512, 512, 4'b0100);
        tick();
        validTri_R13H = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (validSamp_R14H !== 1'b0 || halt_RnnnnL !== 1'b1 || sample_R14S !== '0 || tri_R14S !== '0) begin
            errors++;
            $display("FAIL rstmid_state got valid=%b halt=%b sample=%h tri00=%0d want 0,1,0,0",
                     validSamp_R14H, halt_RnnnnL, sample_R14S, tri_R14S[0][0]);
        end
        tick();
        rst = 1'b0;
        late = 0;
        for (int i = 0; i < 5; i++) begin
            if (validSamp_R14H !== 1'b0) late++;
            tick();
        end
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL rstmid_nosamp got %0d valid cycles after reset want 0", late);
        end
    endtask

    initial begin
        test_reset();
        test_1x();
        test_4x();
        test_degenerate();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_iterator.md
# sample_iterator

Raster-stage iterator that walks every sample position inside a triangle's bounding box and emits one candidate sample per cycle. It takes one triangle at a time from the bounding-box stage under a halt handshake. It produces the sample/triangle/colour stream consumed by the sample-test stage, which performs the edge-equation hit test. Samples are visited in raster order on a grid whose pitch is set by the multisample rate.

## Interface
- SIGFIG, 24: bits in colour and position
- RADIX, 10: fraction bits in colour and position
- VERTS, 3: vertices per triangle
- AXIS, 3: axes per vertex (x,y,z)
- COLORS, 3: colour channels
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; synchronous, active-high
- tri_R13S  in  VERTS×AXIS×SIGFIG signed  triangle from bbox stage
- color_R13U  in  COLORS×SIGFIG  triangle colour
- box_R13S  in  2×2×SIGFIG signed  [0]=lower-left (x,y), [1]=upper-right (x,y), grid-aligned
- validTri_R13H  in  1  triangle/box valid
- subSample_RnnnnU  in  4  one-hot MSAA rate: 1000=1x, 0100=4x, 0010=16x, 0001=64x
- halt_RnnnnL  out  1  low = iterator busy, upstream must hold
- tri_R14S  out  VERTS×AXIS×SIGFIG signed  latched triangle
- color_R14U  out  COLORS×SIGFIG  latched colour
- sample_R14S  out  2×SIGFIG signed  current sample (x,y)
- validSamp_R14H  out  1  sample_R14S is a valid sample

## Operation
- States: WAIT (idle, ready), TEST (emitting samples).
- WAIT: halt_RnnnnL=1, validSamp_R14H=0. Accept occurs when validTri_R13H=1 in WAIT. On the accept edge the block does the following:
  - latch tri, colour, box and step;
  - set sample_R14S to box lower-left;
  - go to TEST.
- Step = (1<<RADIX) >> k, with k=0,1,2,3 for 1x/4x/16x/64x. This gives 1024/512/256/128 at RADIX=10. subSample is sampled only at accept and held for the whole triangle.
- TEST: halt_RnnnnL=0, validSamp_R14H=1 every cycle. Each edge advances the sample as follows:
  - x≠ur_x: x += step.
  - x==ur_x and y≠ur_y: x = ll_x, y += step.
  - x==ur_x and y==ur_y (last sample): go to WAIT.
- Advance arithmetic is SIGFIG-bit signed add with no saturation. The bbox stage guarantees the box is grid-aligned, within the screen, and ll≤ur. Behaviour for a non-aligned box is undefined.
- A degenerate box (ll==ur) gives exactly one sample.
- A validTri_R13H asserted while in TEST is ignored. Upstream holds it under halt low.
- tri_R14S and color_R14U are stable for all samples of a triangle.

## Timing
- Reset (rst=1 at an edge) forces the following on the next cycle:
  - state=WAIT;
  - validSamp_R14H=0, halt_RnnnnL=1;
  - sample_R14S, tri_R14S and color_R14U = 0.
- Reset mid-triangle abandons it. No further samples are emitted.
- halt_RnnnnL is a combinational decode of state, not of inputs.
- Latency: accept at edge N, so the first sample is valid in cycle N+1. A box of W×H grid points gives exactly W·H consecutive valid cycles.
- Without overlap there is one idle WAIT cycle between triangles. Throughput is W·H+1 cycles per triangle.

## Configuration
- SAMPLE_ITER_OVERLAP_EN defined:
  - During the last-sample cycle, halt_RnnnnL=1.
  - If validTri_R13H=1 in that cycle, the next triangle is accepted on the same edge. Its lower-left sample appears in the following cycle, so there is no bubble.
  - validSamp_R14H stays 1 across the boundary.
- Undefined: halt_RnnnnL=1 only in WAIT, giving one bubble cycle per triangle.

## Structure
- Shared raster package: the WAIT/TEST state enum typedef, the subsample one-hot encoding constants, and the step-shift mapping function.
- One sub-module is natural: sample_step_dec. It decodes one-hot subSample into the step value and is registered at accept.
- Output registers are the iteration registers themselves. Use the existing dff for the latched triangle/colour with en = accept.

## Test plan
- Reset: rst high 2 cycles mid-triangle -> next cycle validSamp=0, halt=1, sample=(0,0); no further samples.
- 1x, box ll=(1024,2048) ur=(2048,2048) -> samples (1024,2048),(2048,2048) in cycles N+1,N+2; halt low exactly 2 cycles.
- 4x, box ll=(0,0) ur=(512,512) -> samples (0,0),(512,0),(0,512),(512,512) in order; tri/colour constant.
- Degenerate box ll=ur=(3072,1024), 64x -> exactly one valid sample (3072,1024), then WAIT.
- validTri pulsed with a different triangle during TEST -> ignored; outputs keep the first triangle until its last sample.
- Back-to-back two 1-sample triangles with validTri held high -> macro undefined: valid pattern 1,0,1; macro defined: 1,1.
